// File: rtl/change_dispense_sequencer.sv
// -----------------------------------------------------------------------------
// change_dispense_sequencer
//
// Sequences one vend-and-change event. An accepted request is planned against
// the coin inventory as a dime/nickel mix. The block then lights the vend LED,
// then each dime and each nickel in turn, for HOLD_CYCLES cycles per phase.
// It pulses a counter decrement at the start of every coin slot.
//
// Parameters:
//   HOLD_CYCLES  cycles per LED phase (vend, each dime, each nickel), >= 1
//   W            width of amount, inventory and shortfall buses
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-low reset
//   req_valid      requester has a vend pending
//   req_ready      high only while idle
//   change_amount  cents to return, sampled at accept
//   dime_count     dimes available, sampled in the plan cycle
//   nickel_count   nickels available, sampled in the plan cycle
//   vend_led       product dispense indicator
//   dime_led       dime return indicator
//   nickel_led     nickel return indicator
//   dime_dec       one-cycle dime counter decrement
//   nickel_dec     one-cycle nickel counter decrement
//   busy           high in every state except idle
//   done           one-cycle end-of-sequence pulse
//   shortfall      cents not returned, valid with done/req_reject
//   req_reject     one-cycle refusal pulse (exact-change build only)
//
// Build option:
//   CHANGE_SEQ_EXACT_CHANGE_EN  when defined, a request that cannot be paid
//                               out exactly is refused in the plan cycle.
// -----------------------------------------------------------------------------
module change_dispense_sequencer #(
   parameter int HOLD_CYCLES = 50000000,
   parameter int W           = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [W-1:0] change_amount,
   input  logic [W-1:0] dime_count,
   input  logic [W-1:0] nickel_count,
   output logic         vend_led,
   output logic         dime_led,
   output logic         nickel_led,
   output logic         dime_dec,
   output logic         nickel_dec,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] shortfall,
   output logic         req_reject
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_PLAN   = 3'd1;
   localparam logic [2:0] S_VEND   = 3'd2;
   localparam logic [2:0] S_DIME   = 3'd3;
   localparam logic [2:0] S_NICKEL = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam logic [W+3:0] C10 = (W+4)'(10);
   localparam logic [W+3:0] C5  = (W+4)'(5);

   // Smaller of a wide quotient and a W-bit inventory count; the result always
   // fits W bits because it never exceeds the inventory operand.
   function automatic logic [W-1:0] f_min_w(input logic [W+3:0] a,
                                            input logic [W-1:0] b);
      return (a < {4'b0, b}) ? a[W-1:0] : b;
   endfunction

   // Narrow a wide intermediate to W bits, saturating if the upper bits are set.
   function automatic logic [W-1:0] f_sat_w(input logic [W+3:0] a);
      return (|a[W+3:W]) ? {W{1'b1}} : a[W-1:0];
   endfunction

   logic [2:0]    r_state;
   logic [W-1:0]  r_amt;
   logic [W-1:0]  r_nd;
   logic [W-1:0]  r_nn;
   logic [W-1:0]  r_sf;
   logic [W-1:0]  r_shortfall;
   logic [W-1:0]  r_coin;
   logic [HW-1:0] r_hold;

   logic [W+3:0]  w_amt_x;
   logic [W+3:0]  w_rem_x;
   logic [W-1:0]  w_nd;
   logic [W-1:0]  w_nn;
   logic [W-1:0]  w_sf;
   logic          w_slot_end;

   // Plan arithmetic, evaluated against the live inventory during the plan cycle
   always_comb begin
      w_amt_x = {4'b0, r_amt};
      w_nd    = f_min_w(w_amt_x / C10, dime_count);
      w_rem_x = w_amt_x - ({4'b0, w_nd} * C10);
      w_nn    = f_min_w(w_rem_x / C5, nickel_count);
      w_sf    = f_sat_w(w_rem_x - ({4'b0, w_nn} * C5));
   end

   assign w_slot_end = (r_hold == HOLD_LAST);

`ifdef CHANGE_SEQ_EXACT_CHANGE_EN
   logic r_reject;
   assign req_reject = r_reject;
`else
   assign req_reject = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_amt       <= '0;
         r_nd        <= '0;
         r_nn        <= '0;
         r_sf        <= '0;
         r_shortfall <= '0;
         r_coin      <= '0;
         r_hold      <= '0;
`ifdef CHANGE_SEQ_EXACT_CHANGE_EN
         r_reject    <= 1'b0;
`endif
      end else begin
`ifdef CHANGE_SEQ_EXACT_CHANGE_EN
         r_reject <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_amt       <= change_amount;
                  r_shortfall <= '0;
                  r_state     <= S_PLAN;
               end
            end
            S_PLAN: begin
               r_nd   <= w_nd;
               r_nn   <= w_nn;
               r_sf   <= w_sf;
               r_hold <= '0;
`ifdef CHANGE_SEQ_EXACT_CHANGE_EN
               if (w_sf != '0) begin
                  r_reject    <= 1'b1;
                  r_shortfall <= w_sf;
                  r_state     <= S_IDLE;
               end else begin
                  r_state <= S_VEND;
               end
`else
               r_state <= S_VEND;
`endif
            end
            S_VEND: begin
               if (w_slot_end) begin
                  r_hold <= '0;
                  if (r_nd != '0) begin
                     r_coin  <= r_nd;
                     r_state <= S_DIME;
                  end else if (r_nn != '0) begin
                     r_coin  <= r_nn;
                     r_state <= S_NICKEL;
                  end else begin
                     r_shortfall <= r_sf;
                     r_state     <= S_DONE;
                  end
               end else begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            // r_coin counts slots still to run, including the current one
            S_DIME: begin
               if (w_slot_end) begin
                  r_hold <= '0;
                  if (r_coin == W'(1)) begin
                     if (r_nn != '0) begin
                        r_coin  <= r_nn;
                        r_state <= S_NICKEL;
                     end else begin
                        r_shortfall <= r_sf;
                        r_state     <= S_DONE;
                     end
                  end else begin
                     r_coin <= r_coin - 1'b1;
                  end
               end else begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            S_NICKEL: begin
               if (w_slot_end) begin
                  r_hold <= '0;
                  if (r_coin == W'(1)) begin
                     r_shortfall <= r_sf;
                     r_state     <= S_DONE;
                  end else begin
                     r_coin <= r_coin - 1'b1;
                  end
               end else begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Outputs decode straight from state, so an asserted reset clears them at once
   assign req_ready  = (r_state == S_IDLE);
   assign busy       = (r_state != S_IDLE);
   assign vend_led   = (r_state == S_VEND);
   assign dime_led   = (r_state == S_DIME);
   assign nickel_led = (r_state == S_NICKEL);
   assign dime_dec   = dime_led && (r_hold == '0);
   assign nickel_dec = nickel_led && (r_hold == '0);
   assign done       = (r_state == S_DONE);
   assign shortfall  = r_shortfall;

endmodule
